central_ctrl_fsm: RTL and testbench
===================================

Name: central_ctrl_fsm

Overview:
- Parametrised next-generation central controller for the drum/playback system.
- Sequences standby, count-in, record and playback, and latches user parameters for the audio, graphics and memory modules.
- Adds over the previous controller:
  - generic song/effect widths and a configurable song-address remap;
  - rejection of invalid song selections;
  - a metronome count-in before recording;
  - optional looped playback.

Parameters:
- NUM_SONGS, 12: valid song_name_sel range is 0..NUM_SONGS-1.
- SONG_W, 4: width of song name/choice.
- EFFECT_W, 7: width of effect enable vector.
- EVAL_W, 17: width of packed effect values.
- GAP_START, 6: first song name that is remapped.
- GAP_SIZE, 2: offset added to names >= GAP_START to form song_choice.
- COUNTIN_BEATS, 4: metronome beats before recording; 0 disables count-in.
- BEAT_CYCLES, 6750000: clock cycles per count-in beat; must be >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- but_ent  in  1  start/stop button, synced and debounced
- pause_sw  in  1  1 = paused while running
- loop_en  in  1  1 = restart playback on song_done
- record_mode_sel  in  1  1 = record, 0 = playback
- song_name_sel  in  SONG_W  selected song
- effects_sel  in  EFFECT_W  selected effect enables
- effect_values_sel  in  EVAL_W  selected effect values
- song_done  in  1  end of song from memory module
- effects  out  EFFECT_W  latched effect enables
- effect_values  out  EVAL_W  latched effect values
- record_mode  out  1  latched mode
- song_name  out  SONG_W  latched name, to graphics
- song_choice  out  SONG_W  remapped name, to memory
- start_song  out  1  one-cycle start pulse
- pause_song  out  1  pause to memory
- cfsm_state  out  2  00 IDLE, 01 PLAY, 10 RECORD, 11 COUNTIN
- beat_pulse  out  1  one-cycle metronome tick
- beat_count  out  8  beats emitted in current count-in
- sel_error  out  1  one-cycle pulse on rejected selection

Behaviour:
- Reset (synchronous, active-high, takes effect at the clock edge): cfsm_state=IDLE, pause_song=1, start_song=0, beat_pulse=0, sel_error=0, beat_count=0. All latched outputs are 0.
  - Internal but_ent_prev resets to 1, so a button held through reset does not fire.
  - Reset mid-operation aborts any state to IDLE with no start_song.
- Button edge: edge = but_ent & ~but_ent_prev. but_ent_prev is registered every cycle.
- IDLE: pause_song=1. On an edge:
  - If song_name_sel >= NUM_SONGS: remain IDLE, pulse sel_error for 1 cycle, latch nothing.
  - Otherwise latch effects, effect_values, record_mode, song_name and song_choice.
  - song_choice = song_name_sel if song_name_sel < GAP_START, else song_name_sel + GAP_SIZE, truncated to SONG_W.
  - Next state: PLAY if record_mode_sel=0. If record_mode_sel=1: COUNTIN if COUNTIN_BEATS > 0, else RECORD.
- Start pulse timing: when the state becomes PLAY or RECORD at edge k+1, start_song=1 during cycle k+2 only. Latched configuration is therefore stable one cycle before start.
  - In the cycle before start_song and the start_song cycle itself, pause_song=1.
  - song_done and edge are ignored in those cycles.
- COUNTIN:
  - pause_song=1.
  - A beat counter runs 0..BEAT_CYCLES-1 and starts at 0 on entry.
  - beat_pulse=1 on cycles where the counter is 0; beat_count increments on each pulse.
  - When beat_count == COUNTIN_BEATS and the counter reaches BEAT_CYCLES-1, the next state is RECORD.
  - An edge during COUNTIN returns to IDLE, with no start_song and beat_count cleared.
- PLAY/RECORD, after the start cycle, priority order:
  1. edge -> IDLE, pause_song=1.
  2. song_done -> in PLAY with loop_en=1: stay in PLAY, pause_song=1, start_song re-pulses next cycle. Otherwise -> IDLE, pause_song=1.
  3. Otherwise pause_song <= pause_sw (1-cycle latency).
  - Simultaneous edge and song_done -> IDLE, no restart.
- Latched outputs change only on an accepted IDLE edge. Selection inputs are don't-care in all other states.
- beat_count saturates at 255. It clears on leaving COUNTIN.

Test Plan:
- Playback start: reset; song_name_sel=3, record_mode_sel=0; button rises at cycle 10. Expect cfsm_state=01 at 11, start_song high only at 12, song_choice=3. pause_song then follows pause_sw one cycle later.
- Remap and invalid selection: song_name_sel=7 -> song_choice=9. song_name_sel=12 with NUM_SONGS=12 -> sel_error pulses once, state stays 00, outputs unchanged.
- Count-in (BEAT_CYCLES=4, COUNTIN_BEATS=2): record start. Expect beat_pulse at entry+0 and entry+4, beat_count 1 then 2. Expect RECORD at entry+8 and start_song at entry+9. A second run with a button press at entry+5 returns to IDLE with no start_song.
- Loop: loop_en=1 in PLAY, song_done pulse -> state stays 01, start_song pulses next cycle. Same stimulus with loop_en=0 -> IDLE, pause_song=1.
- Simultaneous events: button edge and song_done in the same cycle in PLAY -> IDLE with no restart. Button held high through reset -> no transition after reset releases.
- Reset mid-RECORD: assert reset for 1 cycle -> state 00, pause_song=1, all latched outputs 0 on the next cycle.

Source files
------------

// File: rtl/central_ctrl_fsm.sv
// Central controller: sequences standby, metronome count-in, record and playback,
// and latches the user's song/effect selection for the audio, graphics and memory blocks.
module central_ctrl_fsm #(
  parameter int NUM_SONGS     = 12,
  parameter int SONG_W        = 4,
  parameter int EFFECT_W      = 7,
  parameter int EVAL_W        = 17,
  parameter int GAP_START     = 6,
  parameter int GAP_SIZE      = 2,
  parameter int COUNTIN_BEATS = 4,
  parameter int BEAT_CYCLES   = 6750000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                but_ent,
  input  logic                pause_sw,
  input  logic                loop_en,
  input  logic                record_mode_sel,
  input  logic [SONG_W-1:0]   song_name_sel,
  input  logic [EFFECT_W-1:0] effects_sel,
  input  logic [EVAL_W-1:0]   effect_values_sel,
  input  logic                song_done,
  output logic [EFFECT_W-1:0] effects,
  output logic [EVAL_W-1:0]   effect_values,
  output logic                record_mode,
  output logic [SONG_W-1:0]   song_name,
  output logic [SONG_W-1:0]   song_choice,
  output logic                start_song,
  output logic                pause_song,
  output logic [1:0]          cfsm_state,
  output logic                beat_pulse,
  output logic [7:0]          beat_count,
  output logic                sel_error
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_PLAY    = 2'b01,
    S_RECORD  = 2'b10,
    S_COUNTIN = 2'b11
  } state_t;

  localparam int              BC_W      = $clog2(BEAT_CYCLES);
  localparam logic [BC_W-1:0] BEAT_LAST = BC_W'(BEAT_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  but_prev_q, but_prev_d;
  logic                  start_pend_q, start_pend_d;
  logic                  start_song_q, start_song_d;
  logic                  pause_song_q, pause_song_d;
  logic                  sel_error_q, sel_error_d;
  logic [BC_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [7:0]            beat_count_q, beat_count_d;
  logic [EFFECT_W-1:0]   effects_q, effects_d;
  logic [EVAL_W-1:0]     effect_values_q, effect_values_d;
  logic                  record_mode_q, record_mode_d;
  logic [SONG_W-1:0]     song_name_q, song_name_d;
  logic [SONG_W-1:0]     song_choice_q, song_choice_d;

  logic                  edge_det;
  logic                  sel_valid;
  logic [SONG_W-1:0]     remapped;

  // Handshake: no valid/ready here; but_ent is a level from the debouncer and only
  // its rising edge (against the registered previous level) is a command.
  always_comb begin
    edge_det   = but_ent & ~but_prev_q;
    sel_valid  = int'(song_name_sel) < NUM_SONGS;
    remapped   = (int'(song_name_sel) < GAP_START) ? song_name_sel
                                                   : SONG_W'(int'(song_name_sel) + GAP_SIZE);
    beat_pulse = (state_q == S_COUNTIN) && (beat_cnt_q == '0);

    state_d         = state_q;
    but_prev_d      = but_ent;
    start_pend_d    = 1'b0;
    start_song_d    = 1'b0;
    pause_song_d    = pause_song_q;
    sel_error_d     = 1'b0;
    beat_cnt_d      = '0;
    beat_count_d    = '0;
    effects_d       = effects_q;
    effect_values_d = effect_values_q;
    record_mode_d   = record_mode_q;
    song_name_d     = song_name_q;
    song_choice_d   = song_choice_q;

    case (state_q)
      S_IDLE: begin
        pause_song_d = 1'b1;
        if (edge_det) begin
          if (!sel_valid) begin
            sel_error_d = 1'b1;
          end else begin
            effects_d       = effects_sel;
            effect_values_d = effect_values_sel;
            record_mode_d   = record_mode_sel;
            song_name_d     = song_name_sel;
            song_choice_d   = remapped;
            if (!record_mode_sel) begin
              state_d      = S_PLAY;
              start_pend_d = 1'b1;
            end else if (COUNTIN_BEATS > 0) begin
              state_d = S_COUNTIN;
            end else begin
              state_d      = S_RECORD;
              start_pend_d = 1'b1;
            end
          end
        end
      end

      S_COUNTIN: begin
        pause_song_d = 1'b1;
        if (edge_det) begin
          state_d = S_IDLE;
        end else if ((int'(beat_count_q) == COUNTIN_BEATS) && (beat_cnt_q == BEAT_LAST)) begin
          state_d      = S_RECORD;
          start_pend_d = 1'b1;
        end else begin
          beat_count_d = (beat_pulse && beat_count_q != 8'hFF) ? beat_count_q + 8'd1
                                                                : beat_count_q;
          beat_cnt_d   = (beat_cnt_q == BEAT_LAST) ? '0 : beat_cnt_q + 1'b1;
        end
      end

      default: begin
        // The entry cycle and the start cycle hold the song paused and ignore events.
        if (start_pend_q) begin
          start_song_d = 1'b1;
          pause_song_d = 1'b1;
        end else if (start_song_q) begin
          pause_song_d = pause_sw;
        end else if (edge_det) begin
          state_d      = S_IDLE;
          pause_song_d = 1'b1;
        end else if (song_done) begin
          pause_song_d = 1'b1;
          if (state_q == S_PLAY && loop_en) begin
            start_song_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          pause_song_d = pause_sw;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      but_prev_q      <= 1'b1;
      start_pend_q    <= 1'b0;
      start_song_q    <= 1'b0;
      pause_song_q    <= 1'b1;
      sel_error_q     <= 1'b0;
      beat_cnt_q      <= '0;
      beat_count_q    <= '0;
      effects_q       <= '0;
      effect_values_q <= '0;
      record_mode_q   <= 1'b0;
      song_name_q     <= '0;
      song_choice_q   <= '0;
    end else begin
      state_q         <= state_d;
      but_prev_q      <= but_prev_d;
      start_pend_q    <= start_pend_d;
      start_song_q    <= start_song_d;
      pause_song_q    <= pause_song_d;
      sel_error_q     <= sel_error_d;
      beat_cnt_q      <= beat_cnt_d;
      beat_count_q    <= beat_count_d;
      effects_q       <= effects_d;
      effect_values_q <= effect_values_d;
      record_mode_q   <= record_mode_d;
      song_name_q     <= song_name_d;
      song_choice_q   <= song_choice_d;
    end
  end

  assign effects       = effects_q;
  assign effect_values = effect_values_q;
  assign record_mode   = record_mode_q;
  assign song_name     = song_name_q;
  assign song_choice   = song_choice_q;
  assign start_song    = start_song_q;
  assign pause_song    = pause_song_q;
  assign cfsm_state    = state_q;
  assign beat_count    = beat_count_q;
  assign sel_error     = sel_error_q;

endmodule

// File: tb/tb_central_ctrl_fsm.sv
// Bench for central_ctrl_fsm: directed scenarios plus random stimulus, every cycle
// compared against a behavioural model built on elapsed-time and mode bookkeeping.
module tb_central_ctrl_fsm;

  localparam int NUM_SONGS     = 12;
  localparam int SONG_W        = 4;
  localparam int EFFECT_W      = 7;
  localparam int EVAL_W        = 17;
  localparam int GAP_START     = 6;
  localparam int GAP_SIZE      = 2;
  localparam int COUNTIN_BEATS = 2;
  localparam int BEAT_CYCLES   = 4;

  logic                clk = 1'b0;
  logic                reset, but_ent, pause_sw, loop_en, record_mode_sel, song_done;
  logic [SONG_W-1:0]   song_name_sel;
  logic [EFFECT_W-1:0] effects_sel;
  logic [EVAL_W-1:0]   effect_values_sel;
  logic [EFFECT_W-1:0] effects;
  logic [EVAL_W-1:0]   effect_values;
  logic                record_mode, start_song, pause_song, beat_pulse, sel_error;
  logic [SONG_W-1:0]   song_name, song_choice;
  logic [1:0]          cfsm_state;
  logic [7:0]          beat_count;

  int checks = 0;
  int failures = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  central_ctrl_fsm #(
    .NUM_SONGS(NUM_SONGS), .SONG_W(SONG_W), .EFFECT_W(EFFECT_W), .EVAL_W(EVAL_W),
    .GAP_START(GAP_START), .GAP_SIZE(GAP_SIZE), .COUNTIN_BEATS(COUNTIN_BEATS),
    .BEAT_CYCLES(BEAT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .but_ent(but_ent), .pause_sw(pause_sw), .loop_en(loop_en),
    .record_mode_sel(record_mode_sel), .song_name_sel(song_name_sel),
    .effects_sel(effects_sel), .effect_values_sel(effect_values_sel), .song_done(song_done),
    .effects(effects), .effect_values(effect_values), .record_mode(record_mode),
    .song_name(song_name), .song_choice(song_choice), .start_song(start_song),
    .pause_song(pause_song), .cfsm_state(cfsm_state), .beat_pulse(beat_pulse),
    .beat_count(beat_count), .sel_error(sel_error)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 play, 2 record, 3 count-in; m_t counts cycles spent in count-in.
  int          m_mode;
  bit          m_prev, m_entering, m_start, m_pause, m_serr;
  int          m_t;
  logic [31:0] m_eff, m_eval, m_rec, m_name, m_choice;

  task automatic model_step();
    bit e;
    int nmode, nt;
    bit nent, nstart, npause;
    e      = but_ent && !m_prev;
    nmode  = m_mode;
    nt     = 0;
    nent   = 0;
    nstart = 0;
    npause = m_pause;
    if (reset) begin
      m_mode = 0; m_prev = 1; m_entering = 0; m_start = 0; m_pause = 1; m_serr = 0; m_t = 0;
      m_eff = 0; m_eval = 0; m_rec = 0; m_name = 0; m_choice = 0;
      return;
    end
    m_serr = 0;
    if (m_mode == 0) begin
      npause = 1;
      if (e && int'(song_name_sel) >= NUM_SONGS) m_serr = 1;
      else if (e) begin
        m_eff  = 32'(effects_sel);
        m_eval = 32'(effect_values_sel);
        m_rec  = 32'(record_mode_sel);
        m_name = 32'(song_name_sel);
        m_choice = (int'(song_name_sel) < GAP_START) ? 32'(song_name_sel)
                 : 32'((int'(song_name_sel) + GAP_SIZE) % (1 << SONG_W));
        if (!record_mode_sel)       begin nmode = 1; nent = 1; end
        else if (COUNTIN_BEATS > 0) nmode = 3;
        else                        begin nmode = 2; nent = 1; end
      end
    end else if (m_mode == 3) begin
      npause = 1;
      if (e) nmode = 0;
      else if (m_t == COUNTIN_BEATS * BEAT_CYCLES - 1) begin nmode = 2; nent = 1; end
      else nt = m_t + 1;
    end else begin
      if (m_entering)      begin nstart = 1; npause = 1; end
      else if (m_start)    npause = pause_sw;
      else if (e)          begin nmode = 0; npause = 1; end
      else if (song_done) begin
        npause = 1;
        if (m_mode == 1 && loop_en) nstart = 1;
        else nmode = 0;
      end else npause = pause_sw;
    end
    m_prev = but_ent; m_mode = nmode; m_t = nt; m_entering = nent; m_start = nstart;
    m_pause = npause;
  endtask

  task automatic compare_all();
    int exp_bc;
    exp_bc = (m_mode == 3) ? (m_t + BEAT_CYCLES - 1) / BEAT_CYCLES : 0;
    if (exp_bc > 255) exp_bc = 255;
    check("m_state", 32'(cfsm_state), m_mode);
    check("m_start", 32'(start_song), 32'(m_start));
    check("m_pause", 32'(pause_song), 32'(m_pause));
    check("m_selerr", 32'(sel_error), 32'(m_serr));
    check("m_beatpulse", 32'(beat_pulse), 32'(m_mode == 3 && (m_t % BEAT_CYCLES) == 0));
    check("m_beatcount", 32'(beat_count), exp_bc);
    check("m_effects", 32'(effects), m_eff);
    check("m_evalues", 32'(effect_values), m_eval);
    check("m_recmode", 32'(record_mode), m_rec);
    check("m_name", 32'(song_name), m_name);
    check("m_choice", 32'(song_choice), m_choice);
  endtask

  // ---------------- driver ----------------
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic press();
    but_ent = 1'b1; cyc();
    but_ent = 1'b0; cyc();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1; but_ent = 0; pause_sw = 0; loop_en = 0; record_mode_sel = 0;
    song_name_sel = '0; effects_sel = '0; effect_values_sel = '0; song_done = 0;
    cyc();
    check("rst_state", 32'(cfsm_state), 0);
    check("rst_pause", 32'(pause_song), 1);
    check("rst_name", 32'(song_name), 0);
    check("rst_beatcount", 32'(beat_count), 0);
    reset = 0;

    // playback start
    song_name_sel = 4'd3; effects_sel = 7'h55; effect_values_sel = 17'h1abcd;
    repeat (9) cyc();
    but_ent = 1; cyc();
    check("play_state", 32'(cfsm_state), 1);
    check("play_nostart", 32'(start_song), 0);
    check("play_choice", 32'(song_choice), 3);
    check("play_effects", 32'(effects), 32'h55);
    but_ent = 0; cyc();
    check("play_start", 32'(start_song), 1);
    check("play_pause_hold", 32'(pause_song), 1);
    pause_sw = 0; cyc();
    check("play_start_once", 32'(start_song), 0);
    check("play_pause_follow0", 32'(pause_song), 0);
    pause_sw = 1; cyc();
    check("play_pause_follow1", 32'(pause_song), 1);
    pause_sw = 0; cyc();
    check("play_pause_follow2", 32'(pause_song), 0);
    press();
    check("stop_state", 32'(cfsm_state), 0);

    // remap and invalid selection
    song_name_sel = 4'd7; press();
    check("remap_choice", 32'(song_choice), 9);
    check("remap_name", 32'(song_name), 7);
    repeat (2) cyc();
    press();
    song_name_sel = 4'd12; but_ent = 1; cyc();
    check("inv_selerr", 32'(sel_error), 1);
    check("inv_state", 32'(cfsm_state), 0);
    check("inv_name_kept", 32'(song_name), 7);
    but_ent = 0; cyc();
    check("inv_selerr_once", 32'(sel_error), 0);

    // count-in then record
    song_name_sel = 4'd2; record_mode_sel = 1; but_ent = 1; cyc();
    check("ci_state", 32'(cfsm_state), 3);
    check("ci_pulse0", 32'(beat_pulse), 1);
    check("ci_count0", 32'(beat_count), 0);
    but_ent = 0;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      if (i == 1) check("ci_count1", 32'(beat_count), 1);
      if (i == 4) check("ci_pulse4", 32'(beat_pulse), 1);
      if (i == 5) check("ci_count2", 32'(beat_count), 2);
      if (i == 8) check("ci_record", 32'(cfsm_state), 2);
      if (i == 9) check("ci_start", 32'(start_song), 1);
    end
    repeat (3) cyc();
    press();
    // count-in aborted by a press
    but_ent = 1; cyc();
    but_ent = 0; repeat (4) cyc();
    but_ent = 1; cyc();
    check("ci_abort_state", 32'(cfsm_state), 0);
    check("ci_abort_count", 32'(beat_count), 0);
    but_ent = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      check("ci_abort_nostart", 32'(start_song), 0);
    end

    // looped playback
    record_mode_sel = 0; press();
    repeat (3) cyc();
    loop_en = 1; song_done = 1; cyc();
    check("loop_state", 32'(cfsm_state), 1);
    check("loop_restart", 32'(start_song), 1);
    check("loop_pause", 32'(pause_song), 1);
    song_done = 0; cyc();
    repeat (2) cyc();
    loop_en = 0; song_done = 1; cyc();
    check("noloop_state", 32'(cfsm_state), 0);
    check("noloop_pause", 32'(pause_song), 1);
    song_done = 0;

    // simultaneous button edge and song_done
    press();
    repeat (3) cyc();
    loop_en = 1; but_ent = 1; song_done = 1; cyc();
    check("simul_state", 32'(cfsm_state), 0);
    but_ent = 0; song_done = 0; cyc();
    check("simul_nostart", 32'(start_song), 0);

    // button held through reset
    but_ent = 1; reset = 1; cyc();
    reset = 0;
    repeat (3) cyc();
    check("held_state", 32'(cfsm_state), 0);
    but_ent = 0; cyc();

    // reset during record
    record_mode_sel = 1; effects_sel = 7'h2a; press();
    repeat (10) cyc();
    check("rec_state", 32'(cfsm_state), 2);
    reset = 1; cyc();
    check("rrst_state", 32'(cfsm_state), 0);
    check("rrst_pause", 32'(pause_song), 1);
    check("rrst_effects", 32'(effects), 0);
    check("rrst_recmode", 32'(record_mode), 0);
    check("rrst_choice", 32'(song_choice), 0);
    reset = 0;

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) == 0) but_ent = ~but_ent;
      if ($urandom_range(0, 5) == 0) pause_sw = ~pause_sw;
      if ($urandom_range(0, 49) == 0) loop_en = 1'($urandom_range(0, 1));
      song_done         = ($urandom_range(0, 24) == 0);
      record_mode_sel   = 1'($urandom_range(0, 1));
      song_name_sel     = SONG_W'($urandom_range(0, (1 << SONG_W) - 1));
      effects_sel       = EFFECT_W'($urandom);
      effect_values_sel = EVAL_W'($urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
